// File: rtl/i_mem_dp.sv
// Dual-port instruction memory: byte-enabled write/load port plus a fetch read port
// with a configurable-latency, holdable read pipeline and selectable read-during-write result.
module i_mem_dp #(
    parameter int DATA_WIDTH   = 128,
    parameter int ADRS_WIDTH   = 32,
    parameter int MEM_DEPTH    = 4096,
    parameter int READ_LATENCY = 1,
    parameter int RDW_NEW_DATA = 0,
    localparam int OFF = $clog2(DATA_WIDTH / 8),
    localparam int AW  = ADRS_WIDTH - OFF,
    localparam int NB  = DATA_WIDTH / 8
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  rd_req,
    input  logic [AW-1:0]         rd_address,
    input  logic                  rd_hold,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_oor,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_address,
    input  logic [NB-1:0]         wr_byte_en,
    input  logic [DATA_WIDTH-1:0] wr_data
);
    localparam int IDX = $clog2(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic [IDX-1:0]        rd_line;
    logic [IDX-1:0]        wr_line;
    logic [DATA_WIDTH-1:0] rd_old;
    logic [DATA_WIDTH-1:0] rd_merged;
    logic                  rd_addr_oor;

    logic                  valid_q [READ_LATENCY];
    logic                  valid_d [READ_LATENCY];
    logic                  oor_q   [READ_LATENCY];
    logic                  oor_d   [READ_LATENCY];
    logic [DATA_WIDTH-1:0] data_q  [READ_LATENCY];
    logic [DATA_WIDTH-1:0] data_d  [READ_LATENCY];

    assign rd_line = rd_address[IDX-1:0];
    assign wr_line = wr_address[IDX-1:0];
    assign rd_old  = mem_q[rd_line];

    // Upper address bits alias onto the array; on the read side they only flag the request.
    generate
        if (AW > IDX) begin : g_hi
            logic wr_hi_unused;
            assign rd_addr_oor  = |rd_address[AW-1:IDX];
            assign wr_hi_unused = ^wr_address[AW-1:IDX];
        end else begin : g_nohi
            assign rd_addr_oor = 1'b0;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (rst_n && wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_byte_en[b]) begin
                    mem_q[wr_line][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Same-line read-during-write: either the pre-write line or the byte-merged new line.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_rdw
            if (RDW_NEW_DATA != 0) begin : g_new
                assign rd_merged[8*gi +: 8] = (wr_en && wr_byte_en[gi] && (wr_line == rd_line))
                                              ? wr_data[8*gi +: 8] : rd_old[8*gi +: 8];
            end else begin : g_old
                assign rd_merged[8*gi +: 8] = rd_old[8*gi +: 8];
            end
        end
    endgenerate

    // Data of a stage only moves with a valid entry, so bubbles leave rd_data at its last line.
    always_comb begin
        for (int s = 0; s < READ_LATENCY; s++) begin
            valid_d[s] = valid_q[s];
            oor_d[s]   = oor_q[s];
            data_d[s]  = data_q[s];
        end
        if (!rd_hold) begin
            valid_d[0] = rd_req;
            oor_d[0]   = rd_req && rd_addr_oor;
            if (rd_req) begin
                data_d[0] = rd_merged;
            end
            for (int s = 1; s < READ_LATENCY; s++) begin
                valid_d[s] = valid_q[s-1];
                oor_d[s]   = oor_q[s-1];
                if (valid_q[s-1]) begin
                    data_d[s] = data_q[s-1];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            for (int s = 0; s < READ_LATENCY; s++) begin
                valid_q[s] <= 1'b0;
                oor_q[s]   <= 1'b0;
                data_q[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < READ_LATENCY; s++) begin
                valid_q[s] <= valid_d[s];
                oor_q[s]   <= oor_d[s];
                data_q[s]  <= data_d[s];
            end
        end
    end

    assign rd_valid = valid_q[READ_LATENCY-1];
    assign rd_oor   = oor_q[READ_LATENCY-1];
    assign rd_data  = data_q[READ_LATENCY-1];

endmodule
